cordic_sched: RTL and testbench
===============================

Name: cordic_sched

Overview:
- Shares one iterative CORDIC rotation core between NCH phase/angle channels.
- Each channel presents an angle with a request/acknowledge handshake.
- The block arbitrates round-robin, issues a start to the core with fixed start vector (x = X_INIT, y = 0), waits for done with a timeout watchdog, and returns cos/sin tagged with the channel index.
- Sits between the per-channel angle generators and the CORDIC core.

Parameters:
- NCH, 4, number of requesting channels (power of 2, ≥2)
- CH_W, 2, channel index width, = log2(NCH)
- width, 12, angle and x/y datapath width
- X_INIT, 1215, start x value (2000*0.6073 gain pre-compensation)
- TIMEOUT, 64, max cycles in WAIT before abort
- TO_W, 7, timeout counter width; must hold TIMEOUT

Ports:
- clock, input, 1, system clock, rising edge
- reset, input, 1, asynchronous, active-high reset
- ch_req, input, NCH, per-channel request; held until acked
- ch_angle, input, NCH*width, packed angles; channel i at bits [i*width +: width]
- ch_ack, output, NCH, one-hot, one-cycle grant pulse
- cor_start, output, 1, one-cycle start pulse to core
- cor_x, output, width, core start x
- cor_y, output, width, core start y
- cor_angle, output, width, core target angle
- cor_done, input, 1, core result-valid pulse
- cor_xout, input, width, core cos result
- cor_yout, input, width, core sin result
- res_valid, output, 1, one-cycle result pulse
- res_ch, output, CH_W, channel owning the result
- res_cos, output, width, captured cos
- res_sin, output, width, captured sin
- timeout_err, output, 1, sticky watchdog flag
- err_ch, output, CH_W, channel whose operation timed out
- clr_err, input, 1, clears timeout_err

Behaviour:
- Reset (async, active-high): every output is 0; state = IDLE; round-robin pointer last_grant = NCH-1, so ch0 has first priority; watchdog counter = 0.
- All outputs are registered.
- FSM states: IDLE, WAIT.
- IDLE:
  - If ch_req is nonzero, grant the first requesting channel searching upward from last_grant+1 mod NCH.
  - On that edge register: ch_ack = onehot(g), cor_start = 1, cor_angle = ch_angle[g], cor_x = X_INIT, cor_y = 0, cur_ch = g, last_grant = g. Go to WAIT and clear the counter.
  - If ch_req is zero, stay in IDLE with no pulses.
- ch_ack and cor_start are high for exactly one cycle, the same cycle, which is the first cycle of WAIT.
- WAIT:
  - Counter increments each cycle.
  - On cor_done: capture res_cos = cor_xout, res_sin = cor_yout, res_ch = cur_ch; res_valid = 1 next cycle; go to IDLE.
  - If the counter reaches TIMEOUT-1 with no cor_done: set timeout_err = 1 and err_ch = cur_ch, go to IDLE, no res_valid. The request is dropped and the channel must re-request.
  - cor_done and timeout on the same edge: done wins, no error.
- cor_done is ignored in IDLE.
- Back-to-back: a new grant may occur on the edge after the done edge, i.e. ack coincides with res_valid. Throughput is one operation per (core latency + 1) cycles.
- A request that stays high after its ack counts as a new request. Round-robin still rotates to other requesters first.
- A request deasserted before ack is never granted; no partial state.
- res_cos, res_sin and res_ch hold their values until the next capture. res_valid is a pulse.
- timeout_err:
  - clr_err clears it the next cycle.
  - If a set and clr_err occur on the same edge, the set wins.
  - err_ch holds the last erroring channel.
- Reset mid-operation: in-flight result lost, FSM to IDLE. The core shares the same reset.
- Widths: no arithmetic on data; angles pass through unmodified, wrap is owned by the generator. The pointer increment wraps mod NCH (natural CH_W overflow).

Decomposition:
- Shared package cordic_pkg:
  - state encoding (IDLE=1'b0, WAIT=1'b1)
  - X_INIT constant
  - default width/NCH/TIMEOUT constants
- Sub-module rr_arbiter: combinational one-hot grant from ch_req and last_grant (rotate, priority-encode, rotate back), plus the binary index. The FSM, watchdog and result registers stay in cordic_sched.

Test Plan:
- Single request: after reset, ch_req=4'b0100 with ch2 angle 12'h07F. Required: ch_ack=4'b0100 and cor_start with cor_angle=12'h07F, cor_x=1215, cor_y=0 in the cycle after the request edge. Core model gives done after 12 cycles with xout=12'h3A0, yout=12'h0C1 → one cycle later res_valid=1, res_ch=2, res_cos=12'h3A0, res_sin=12'h0C1.
- Round-robin fairness: ch_req=4'b1111 held, core latency 5 → grant order 0,1,2,3,0. Each ack coincides with the previous res_valid; no channel is granted twice before all four are served.
- Timeout: core never asserts done → timeout_err=1 and err_ch=granted channel TIMEOUT cycles after cor_start, no res_valid, FSM back in IDLE. clr_err pulse clears the flag; clr_err and a second timeout on the same edge → flag stays 1.
- Done at timeout edge: cor_done on the cycle the counter hits TIMEOUT-1 → res_valid=1, timeout_err remains 0.
- Reset mid-WAIT: assert reset 3 cycles after cor_start, asynchronously between edges → all outputs 0 immediately. After release, ch0 wins over ch3 when both request.
- Spurious done: cor_done pulsed in IDLE with no request → no res_valid, res_* registers unchanged.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and FSM encoding for the CORDIC channel scheduler.
package cordic_pkg;

  localparam int NCH_DEF     = 4;
  localparam int CH_W_DEF    = 2;
  localparam int WIDTH_DEF   = 12;
  localparam int TIMEOUT_DEF = 64;
  localparam int TO_W_DEF    = 7;

  // Start x with the CORDIC gain pre-compensated (2000 * 0.6073).
  localparam int X_INIT_DEF  = 1215;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the channel after last_i has top priority.
// Combinational; the scheduler registers its outputs.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] last_i,
  output logic [NCH-1:0]  gnt_oh_o,
  output logic [CH_W-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  logic [CH_W-1:0] start_s;
  logic [NCH-1:0]  rot_s;
  logic [CH_W-1:0] pos_s;

  // Search begins one past the last winner; CH_W overflow gives the wrap.
  assign start_s = last_i + CH_W'(1);

  // Rotate requests so that bit 0 is the highest-priority channel.
  always_comb begin
    rot_s = '0;
    for (int i = 0; i < NCH; i++) begin
      rot_s[i] = req_i[CH_W'(i) + start_s];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    pos_s = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      pos_s = rot_s[i] ? CH_W'(i) : pos_s;
    end
  end

  // Rotate the winning position back to a channel index and one-hot grant.
  always_comb begin
    gnt_idx_o          = pos_s + start_s;
    gnt_valid_o        = |req_i;
    gnt_oh_o           = '0;
    gnt_oh_o[gnt_idx_o] = gnt_valid_o;
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one iterative CORDIC core between NCH angle channels: round-robin
// grant, start pulse to the core, watchdog on done, tagged result return.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int CH_W    = CH_W_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int X_INIT  = X_INIT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH-1:0]       ch_req,
  input  logic [NCH*WIDTH-1:0] ch_angle,
  output logic [NCH-1:0]       ch_ack,
  output logic                 cor_start,
  output logic [WIDTH-1:0]     cor_x,
  output logic [WIDTH-1:0]     cor_y,
  output logic [WIDTH-1:0]     cor_angle,
  input  logic                 cor_done,
  input  logic [WIDTH-1:0]     cor_xout,
  input  logic [WIDTH-1:0]     cor_yout,
  output logic                 res_valid,
  output logic [CH_W-1:0]      res_ch,
  output logic [WIDTH-1:0]     res_cos,
  output logic [WIDTH-1:0]     res_sin,
  output logic                 timeout_err,
  output logic [CH_W-1:0]      err_ch,
  input  logic                 clr_err
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] last_q, last_d;
  logic [CH_W-1:0] cur_q, cur_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic            start_q, start_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, angle_q, angle_d;
  logic            cap_q, cap_d;
  logic            rv_q;
  logic [CH_W-1:0] res_ch_q, res_ch_d;
  logic [WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;
  logic            terr_q, terr_d;
  logic [CH_W-1:0] err_ch_q, err_ch_d;
  logic            to_set_s;

  logic [NCH-1:0]   gnt_oh_s;
  logic [CH_W-1:0]  gnt_idx_s;
  logic             gnt_valid_s;
  logic [WIDTH-1:0] ang_s [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ang
    assign ang_s[i] = ch_angle[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .req_i       (ch_req),
    .last_i      (last_q),
    .gnt_oh_o    (gnt_oh_s),
    .gnt_idx_o   (gnt_idx_s),
    .gnt_valid_o (gnt_valid_s)
  );

  // Next-state, grant, watchdog and result-capture logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    cur_d    = cur_q;
    ack_d    = '0;
    start_d  = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    angle_d  = angle_q;
    cap_d    = 1'b0;
    res_ch_d = res_ch_q;
    cos_d    = cos_q;
    sin_d    = sin_q;
    err_ch_d = err_ch_q;
    to_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          ack_d   = gnt_oh_s;
          start_d = 1'b1;
          angle_d = ang_s[gnt_idx_s];
          x_d     = WIDTH'(X_INIT);
          y_d     = '0;
          cur_d   = gnt_idx_s;
          last_d  = gnt_idx_s;
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        // Done takes precedence over an expiring watchdog on the same edge.
        if (cor_done) begin
          cos_d    = cor_xout;
          sin_d    = cor_yout;
          res_ch_d = cur_q;
          cap_d    = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          to_set_s = 1'b1;
          err_ch_d = cur_q;
          state_d  = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A new error outranks a simultaneous clear.
    if (to_set_s) begin
      terr_d = 1'b1;
    end else if (clr_err) begin
      terr_d = 1'b0;
    end else begin
      terr_d = terr_q;
    end
  end

  // State and output registers; res_valid trails the capture by one cycle so
  // it lines up with the ack of a back-to-back grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= CH_W'(NCH - 1);
      cur_q    <= '0;
      ack_q    <= '0;
      start_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      angle_q  <= '0;
      cap_q    <= 1'b0;
      rv_q     <= 1'b0;
      res_ch_q <= '0;
      cos_q    <= '0;
      sin_q    <= '0;
      terr_q   <= 1'b0;
      err_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      ack_q    <= ack_d;
      start_q  <= start_d;
      x_q      <= x_d;
      y_q      <= y_d;
      angle_q  <= angle_d;
      cap_q    <= cap_d;
      rv_q     <= cap_q;
      res_ch_q <= res_ch_d;
      cos_q    <= cos_d;
      sin_q    <= sin_d;
      terr_q   <= terr_d;
      err_ch_q <= err_ch_d;
    end
  end

  assign ch_ack      = ack_q;
  assign cor_start   = start_q;
  assign cor_x       = x_q;
  assign cor_y       = y_q;
  assign cor_angle   = angle_q;
  assign res_valid   = rv_q;
  assign res_ch      = res_ch_q;
  assign res_cos     = cos_q;
  assign res_sin     = sin_q;
  assign timeout_err = terr_q;
  assign err_ch      = err_ch_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched: directed table, corner sequences and
// a randomized run scored against a transaction-level model.
module tb_cordic_sched;

  localparam int NCH = 4;
  localparam int CH_W = 2;
  localparam int W = 12;
  localparam int TIMEOUT = 64;
  localparam int TO_W = 7;

  logic           clock, reset;
  logic [NCH-1:0] ch_req;
  logic [NCH*W-1:0] ch_angle;
  logic [NCH-1:0] ch_ack;
  logic           cor_start, cor_done, res_valid, timeout_err, clr_err;
  logic [W-1:0]   cor_x, cor_y, cor_angle, cor_xout, cor_yout, res_cos, res_sin;
  logic [CH_W-1:0] res_ch, err_ch;

  cordic_sched #(.NCH(NCH), .CH_W(CH_W), .WIDTH(W), .X_INIT(1215),
                 .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clock(clock), .reset(reset), .ch_req(ch_req), .ch_angle(ch_angle),
    .ch_ack(ch_ack), .cor_start(cor_start), .cor_x(cor_x), .cor_y(cor_y),
    .cor_angle(cor_angle), .cor_done(cor_done), .cor_xout(cor_xout),
    .cor_yout(cor_yout), .res_valid(res_valid), .res_ch(res_ch),
    .res_cos(res_cos), .res_sin(res_sin), .timeout_err(timeout_err),
    .err_ch(err_ch), .clr_err(clr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass, n_checks;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  ack;
    int          ch;
    logic [11:0] angle;
    int          lat;
    logic [11:0] xo;
    logic [11:0] yo;
  } vec_t;

  typedef struct {
    int          ch;
    logic [11:0] c;
    logic [11:0] s;
  } res_t;

  vec_t        tbl [6];
  logic [W-1:0] ang_tab [NCH];
  res_t        q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ch_req = '0; cor_done = 1'b0; clr_err = 1'b0;
    #2;
    step();
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, 32'(ch_ack), 32'h0);
    check({tag, "_start"}, 32'(cor_start), 32'h0);
    check({tag, "_x"}, 32'(cor_x), 32'h0);
    check({tag, "_y"}, 32'(cor_y), 32'h0);
    check({tag, "_angle"}, 32'(cor_angle), 32'h0);
    check({tag, "_rv"}, 32'(res_valid), 32'h0);
    check({tag, "_rch"}, 32'(res_ch), 32'h0);
    check({tag, "_cos"}, 32'(res_cos), 32'h0);
    check({tag, "_sin"}, 32'(res_sin), 32'h0);
    check({tag, "_terr"}, 32'(timeout_err), 32'h0);
    check({tag, "_errch"}, 32'(err_ch), 32'h0);
  endtask

  // Round-robin rule: first requester searching upward from last+1 mod NCH.
  function automatic int rr_pick(input logic [NCH-1:0] req, input int last);
    for (int k = 1; k <= NCH; k++) begin
      if (req[(last + k) % NCH]) return (last + k) % NCH;
    end
    return -1;
  endfunction

  initial begin
    int n, pick, m_last, cd;
    logic saw_rv, busy, rv_pipe, exp_rv, exp_ack, done_snap;
    logic [NCH-1:0] req_snap, exp_oh;
    logic [NCH*W-1:0] ang_snap;
    logic [W-1:0] a, core_ang;
    res_t e;

    n_pass = 0; n_checks = 0;
    reset = 1'b1; ch_req = '0; cor_done = 1'b0; clr_err = 1'b0;
    cor_xout = '0; cor_yout = '0;
    ang_tab[0] = 12'h111; ang_tab[1] = 12'h800; ang_tab[2] = 12'h07F; ang_tab[3] = 12'hFFF;
    for (int i = 0; i < NCH; i++) ch_angle[i*W +: W] = ang_tab[i];

    tbl[0] = '{req:4'b0100, ack:4'b0100, ch:2, angle:12'h07F, lat:12, xo:12'h3A0, yo:12'h0C1};
    tbl[1] = '{req:4'b1000, ack:4'b1000, ch:3, angle:12'hFFF, lat:1,  xo:12'hFFF, yo:12'h000};
    tbl[2] = '{req:4'b1010, ack:4'b0010, ch:1, angle:12'h800, lat:3,  xo:12'h001, yo:12'hFFE};
    tbl[3] = '{req:4'b1100, ack:4'b0100, ch:2, angle:12'h07F, lat:7,  xo:12'h5A5, yo:12'hA5A};
    tbl[4] = '{req:4'b1111, ack:4'b0001, ch:0, angle:12'h111, lat:2,  xo:12'h7FF, yo:12'h800};
    tbl[5] = '{req:4'b0110, ack:4'b0010, ch:1, angle:12'h800, lat:4,  xo:12'h123, yo:12'h456};

    // Directed single operations after reset
    for (int k = 0; k < 6; k++) begin
      do_reset();
      if (k == 0) check_zero("reset");
      ch_req = tbl[k].req;
      step();
      check("tbl_ack", 32'(ch_ack), 32'(tbl[k].ack));
      check("tbl_start", 32'(cor_start), 32'h1);
      check("tbl_angle", 32'(cor_angle), 32'(tbl[k].angle));
      check("tbl_x", 32'(cor_x), 32'd1215);
      check("tbl_y", 32'(cor_y), 32'h0);
      ch_req = '0;
      repeat (tbl[k].lat - 1) begin
        step();
        check("tbl_wait_start", 32'(cor_start), 32'h0);
      end
      cor_done = 1'b1; cor_xout = tbl[k].xo; cor_yout = tbl[k].yo;
      step();
      cor_done = 1'b0;
      step();
      check("tbl_rv", 32'(res_valid), 32'h1);
      check("tbl_rch", 32'(res_ch), 32'(tbl[k].ch));
      check("tbl_cos", 32'(res_cos), 32'(tbl[k].xo));
      check("tbl_sin", 32'(res_sin), 32'(tbl[k].yo));
      step();
      check("tbl_rv_pulse", 32'(res_valid), 32'h0);
      check("tbl_cos_hold", 32'(res_cos), 32'(tbl[k].xo));
    end

    // Round-robin fairness with all channels requesting, latency 5
    do_reset();
    ch_req = 4'hF;
    step();
    check("rr_ack0", 32'(ch_ack), 32'h1);
    for (int j = 1; j <= 4; j++) begin
      repeat (4) step();
      cor_done = 1'b1; cor_xout = 12'(12'h100 + j); cor_yout = 12'(12'h200 + j);
      step();
      cor_done = 1'b0;
      check("rr_gap_ack", 32'(ch_ack), 32'h0);
      step();
      check("rr_ack", 32'(ch_ack), 32'(1 << (j % NCH)));
      check("rr_rv", 32'(res_valid), 32'h1);
      check("rr_rch", 32'(res_ch), 32'(j - 1));
      check("rr_cos", 32'(res_cos), 32'(12'h100 + j));
    end
    ch_req = '0;

    // Watchdog: core never answers
    do_reset();
    ch_req = 4'b0010;
    step();
    check("to_ack", 32'(ch_ack), 32'h2);
    ch_req = '0;
    n = 0; saw_rv = 1'b0;
    while (timeout_err !== 1'b1 && n < 200) begin
      step();
      n++;
      if (res_valid === 1'b1) saw_rv = 1'b1;
    end
    check("to_latency", 32'(n), 32'(TIMEOUT));
    check("to_errch", 32'(err_ch), 32'h1);
    check("to_no_rv", 32'(saw_rv), 32'h0);
    ch_req = 4'b0100;
    step();
    check("to_idle_regrant", 32'(ch_ack), 32'h4);
    ch_req = '0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("to_clr", 32'(timeout_err), 32'h0);
    repeat (62) step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("to_set_wins", 32'(timeout_err), 32'h1);
    check("to_errch2", 32'(err_ch), 32'h2);

    // Done on the same edge the watchdog expires
    clr_err = 1'b1; ch_req = 4'b1000;
    step();
    clr_err = 1'b0; ch_req = '0;
    check("dt_ack", 32'(ch_ack), 32'h8);
    check("dt_clr", 32'(timeout_err), 32'h0);
    repeat (63) step();
    cor_done = 1'b1; cor_xout = 12'hABC; cor_yout = 12'h123;
    step();
    cor_done = 1'b0;
    check("dt_no_err", 32'(timeout_err), 32'h0);
    step();
    check("dt_rv", 32'(res_valid), 32'h1);
    check("dt_cos", 32'(res_cos), 32'hABC);
    check("dt_rch", 32'(res_ch), 32'h3);

    // Asynchronous reset three cycles into WAIT
    ch_req = 4'b0001;
    step();
    check("rst_ack", 32'(ch_ack), 32'h1);
    ch_req = '0;
    repeat (3) step();
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    #2 reset = 1'b0;
    ch_req = 4'b1001;
    step();
    check("rst_prio", 32'(ch_ack), 32'h1);
    ch_req = '0;

    // Spurious done in IDLE leaves results alone
    cor_done = 1'b1; cor_xout = 12'h246; cor_yout = 12'h135;
    step();
    cor_done = 1'b0;
    step();
    check("sp_rv_first", 32'(res_valid), 32'h1);
    check("sp_cos_first", 32'(res_cos), 32'h246);
    cor_done = 1'b1; cor_xout = 12'h999; cor_yout = 12'h888;
    step();
    cor_done = 1'b0;
    step();
    check("sp_no_rv", 32'(res_valid), 32'h0);
    check("sp_cos_hold", 32'(res_cos), 32'h246);
    check("sp_sin_hold", 32'(res_sin), 32'h135);
    check("sp_no_ack", 32'(ch_ack), 32'h0);

    // Randomized traffic against the transaction-level model
    do_reset();
    m_last = NCH - 1; busy = 1'b0; rv_pipe = 1'b0; cd = 0; core_ang = '0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_snap = ch_req; ang_snap = ch_angle; done_snap = cor_done;
      step();
      exp_ack = !busy && (req_snap != '0);
      exp_rv = rv_pipe;
      rv_pipe = done_snap && busy;
      if (rv_pipe) busy = 1'b0;
      check("rnd_rv", 32'(res_valid), 32'(exp_rv));
      if (exp_rv && q.size() > 0) begin
        e = q.pop_front();
        check("rnd_rch", 32'(res_ch), 32'(e.ch));
        check("rnd_cos", 32'(res_cos), 32'(e.c));
        check("rnd_sin", 32'(res_sin), 32'(e.s));
      end
      exp_oh = '0;
      pick = 0;
      if (exp_ack) begin
        pick = rr_pick(req_snap, m_last);
        m_last = pick;
        exp_oh[pick] = 1'b1;
      end
      check("rnd_ack", 32'(ch_ack), 32'(exp_oh));
      check("rnd_start", 32'(cor_start), 32'(exp_ack));
      if (exp_ack) begin
        a = ang_snap[pick*W +: W];
        check("rnd_angle", 32'(cor_angle), 32'(a));
        check("rnd_x", 32'(cor_x), 32'd1215);
        q.push_back('{ch:pick, c:(a ^ 12'h5A5), s:(~a)});
        busy = 1'b1;
        cd = int'($urandom_range(1, 12));
        core_ang = a;
      end
      cor_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          cor_done = 1'b1;
          cor_xout = core_ang ^ 12'h5A5;
          cor_yout = ~core_ang;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (exp_oh[i]) begin
          if ($urandom_range(0, 3) != 0) ch_req[i] = 1'b0;
        end else if (!ch_req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            ch_req[i] = 1'b1;
            ch_angle[i*W +: W] = W'($urandom);
          end
        end else if ($urandom_range(0, 31) == 0) begin
          ch_req[i] = 1'b0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
